// File: rtl/out_signature_collector_if.sv
// Kernel-side channel/control signals and board-side result signals of the output collector.
interface out_signature_collector_if #(
    parameter int NUM_CH    = 2,
    parameter int DIN_WIDTH = 32,
    parameter int OUT_WIDTH = 4,
    parameter int CNT_WIDTH = 32
) ();
    logic [NUM_CH*DIN_WIDTH-1:0] ch_din;
    logic [NUM_CH-1:0]           ch_write;
    logic                        ap_start;
    logic                        ap_done;
    logic [OUT_WIDTH-1:0]        data_out;
    logic                        data_valid;
    logic [DIN_WIDTH-1:0]        sig_out;
    logic [CNT_WIDTH-1:0]        word_cnt_out;
    logic [CNT_WIDTH-1:0]        run_count;
    logic                        sig_valid;

    modport master (
        output ch_din, ch_write, ap_start, ap_done,
        input  data_out, data_valid, sig_out, word_cnt_out, run_count, sig_valid
    );

    modport slave (
        input  ch_din, ch_write, ap_start, ap_done,
        output data_out, data_valid, sig_out, word_cnt_out, run_count, sig_valid
    );
endinterface

// File: rtl/out_signature_collector.sv
// Folds NUM_CH kernel output channels to OUT_WIDTH bits through a 3-stage XOR pipeline and
// accumulates a rotating per-run signature plus saturating word count between ap_start and ap_done.
module out_signature_collector #(
    parameter int NUM_CH    = 2,
    parameter int DIN_WIDTH = 32,
    parameter int OUT_WIDTH = 4,
    parameter int CNT_WIDTH = 32
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    out_signature_collector_if.slave bus
);
    localparam int NB = DIN_WIDTH / 8;
    localparam int NS = 8 / OUT_WIDTH;
    localparam int NW = $clog2(NUM_CH + 1);
    localparam int SW = CNT_WIDTH + NW;

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_FLUSH0, S_FLUSH1, S_REPORT} state_t;

    function automatic logic [7:0] byte_xor(input logic [DIN_WIDTH-1:0] word);
        logic [7:0] acc;
        acc = '0;
        for (int b = 0; b < NB; b++) acc = acc ^ word[b*8 +: 8];
        return acc;
    endfunction

    function automatic logic [OUT_WIDTH-1:0] slice_xor(input logic [7:0] f);
        logic [OUT_WIDTH-1:0] acc;
        acc = '0;
        for (int s = 0; s < NS; s++) acc = acc ^ f[s*OUT_WIDTH +: OUT_WIDTH];
        return acc;
    endfunction

    logic [DIN_WIDTH-1:0] w_word [NUM_CH];
    logic [7:0]           w_fold [NUM_CH];

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign w_word[gi] = bus.ch_din[gi*DIN_WIDTH +: DIN_WIDTH];
            assign w_fold[gi] = byte_xor(w_word[gi]);
        end
    endgenerate

    // ---------------- stage 1 ----------------
    logic [DIN_WIDTH-1:0] w_w1_next;
    logic [NW-1:0]        w_n1_next;

    always_comb begin
        w_w1_next = '0;
        w_n1_next = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (bus.ch_write[c]) begin
                w_w1_next = w_w1_next ^ w_word[c];
                w_n1_next = w_n1_next + NW'(1);
            end
        end
    end

    logic [NUM_CH-1:0]    r_v1;
    logic [7:0]           r_f1 [NUM_CH];
    logic [DIN_WIDTH-1:0] r_w1;
    logic [NW-1:0]        r_n1;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_v1 <= '0;
            r_w1 <= '0;
            r_n1 <= '0;
            for (int c = 0; c < NUM_CH; c++) r_f1[c] <= '0;
        end else begin
            r_v1 <= bus.ch_write;
            r_w1 <= w_w1_next;
            r_n1 <= w_n1_next;
            for (int c = 0; c < NUM_CH; c++) r_f1[c] <= w_fold[c];
        end
    end

    // ---------------- stages 2 and 3 ----------------
    logic [7:0]           w_f2_next;
    logic                 w_any_v1;
    logic                 r_v2;
    logic [7:0]           r_f2;
    logic                 r_data_valid;
    logic [OUT_WIDTH-1:0] r_data_out;

    assign w_any_v1 = |r_v1;

    always_comb begin
        w_f2_next = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (r_v1[c]) w_f2_next = w_f2_next ^ r_f1[c];
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_v2         <= 1'b0;
            r_f2         <= '0;
            r_data_valid <= 1'b0;
            r_data_out   <= '0;
        end else begin
            r_v2         <= w_any_v1;
            r_f2         <= w_f2_next;
            r_data_valid <= r_v2;
            r_data_out   <= slice_xor(r_f2);
        end
    end

    // ---------------- run FSM ----------------
    state_t r_state;
    state_t w_state_next;
    logic   w_sig_valid;
    logic   w_accum_en;
    logic   w_run_clear;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) r_state <= S_IDLE;
        else           r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.ap_start) w_state_next = S_RUN;
            S_RUN:    if (bus.ap_done)  w_state_next = S_FLUSH0;
            S_FLUSH0: w_state_next = S_FLUSH1;
            S_FLUSH1: w_state_next = S_REPORT;
            S_REPORT: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Flush states keep accumulating so words written alongside ap_done drain out of stage 1.
    always_comb begin
        w_sig_valid = (r_state == S_REPORT);
        w_accum_en  = (r_state == S_RUN) || (r_state == S_FLUSH0) || (r_state == S_FLUSH1);
        w_run_clear = (r_state == S_IDLE) && bus.ap_start;
    end

    // ---------------- signature / counters ----------------
    logic [DIN_WIDTH-1:0] r_sig;
    logic [CNT_WIDTH-1:0] r_wcnt;
    logic [SW-1:0]        w_sum;
    logic [CNT_WIDTH-1:0] w_wcnt_next;
    logic [DIN_WIDTH-1:0] w_sig_next;

    assign w_sum       = SW'(r_wcnt) + SW'(r_n1);
    assign w_wcnt_next = (w_sum[SW-1:CNT_WIDTH] != '0) ? '1 : w_sum[CNT_WIDTH-1:0];
    assign w_sig_next  = {r_sig[DIN_WIDTH-2:0], r_sig[DIN_WIDTH-1]} ^ r_w1;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_sig  <= '0;
            r_wcnt <= '0;
        end else if (w_run_clear) begin
            r_sig  <= '0;
            r_wcnt <= '0;
        end else if (w_accum_en && w_any_v1) begin
            r_sig  <= w_sig_next;
            r_wcnt <= w_wcnt_next;
        end
    end

    logic [DIN_WIDTH-1:0] r_sig_out;
    logic [CNT_WIDTH-1:0] r_word_cnt_out;
    logic [CNT_WIDTH-1:0] r_run_count;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_sig_out      <= '0;
            r_word_cnt_out <= '0;
            r_run_count    <= '0;
        end else if (w_sig_valid) begin
            r_sig_out      <= r_sig;
            r_word_cnt_out <= r_wcnt;
            r_run_count    <= r_run_count + CNT_WIDTH'(1);
        end
    end

    assign bus.data_out     = r_data_out;
    assign bus.data_valid   = r_data_valid;
    assign bus.sig_out      = r_sig_out;
    assign bus.word_cnt_out = r_word_cnt_out;
    assign bus.run_count    = r_run_count;
    assign bus.sig_valid    = w_sig_valid;
endmodule

// File: tb/tb_out_signature_collector.sv
// Directed bench: two collectors (32-bit and 4-bit counters) share stimulus; a cycle model checks both.
module tb_out_signature_collector;
    localparam int NC = 2;
    localparam int DW = 32;
    localparam int OW = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NC*DW-1:0] ch_din = '0;
    logic [NC-1:0]    ch_write = '0;
    logic             ap_start = 1'b0;
    logic             ap_done = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    out_signature_collector_if #(.NUM_CH(NC), .DIN_WIDTH(DW), .OUT_WIDTH(OW), .CNT_WIDTH(32)) if32 ();
    out_signature_collector_if #(.NUM_CH(NC), .DIN_WIDTH(DW), .OUT_WIDTH(OW), .CNT_WIDTH(4))  if4 ();

    assign if32.ch_din   = ch_din;
    assign if32.ch_write = ch_write;
    assign if32.ap_start = ap_start;
    assign if32.ap_done  = ap_done;
    assign if4.ch_din    = ch_din;
    assign if4.ch_write  = ch_write;
    assign if4.ap_start  = ap_start;
    assign if4.ap_done   = ap_done;

    out_signature_collector #(.NUM_CH(NC), .DIN_WIDTH(DW), .OUT_WIDTH(OW), .CNT_WIDTH(32)) u_dut32 (
        .ap_clk(clk), .ap_rst_n(rst_n), .bus(if32));
    out_signature_collector #(.NUM_CH(NC), .DIN_WIDTH(DW), .OUT_WIDTH(OW), .CNT_WIDTH(4)) u_dut4 (
        .ap_clk(clk), .ap_rst_n(rst_n), .bus(if4));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] bytes_xor(input logic [31:0] w);
        return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
    endfunction

    function automatic logic [3:0] fold4(input logic [7:0] f);
        return f[3:0] ^ f[7:4];
    endfunction

    // ---------------- behavioural model + per-cycle compare ----------------
    logic        m_dv [3];
    logic [3:0]  m_do [3];
    int          mode;          // 0 idle, 1 collecting, 2 done seen
    int          cyc, start_n, last_collect, report_at;
    logic [31:0] m_sig, h_sig;
    longint      m_cnt, h_cnt;
    int          h_runs;
    logic        m_sv;

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin m_dv[i] = 1'b0; m_do[i] = '0; end
        mode = 0; cyc = 0; start_n = 0; last_collect = -1; report_at = -1;
        m_sig = '0; m_cnt = 0; h_sig = '0; h_cnt = 0; h_runs = 0; m_sv = 1'b0;
    endtask

    initial begin
        logic [31:0] wx;
        logic [7:0]  fx;
        int          nw;
        model_clear();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_dv32",  if32.data_valid, 0);
                chk("rst_do32",  if32.data_out, 0);
                chk("rst_sv32",  if32.sig_valid, 0);
                chk("rst_sig32", if32.sig_out, 0);
                chk("rst_cnt32", if32.word_cnt_out, 0);
                chk("rst_rc32",  if32.run_count, 0);
                chk("rst_rc4",   if4.run_count, 0);
                model_clear();
            end else begin
                chk("dv32",  if32.data_valid, m_dv[2]);
                chk("do32",  if32.data_out, m_do[2]);
                chk("sv32",  if32.sig_valid, m_sv);
                chk("sig32", if32.sig_out, h_sig);
                chk("cnt32", if32.word_cnt_out, h_cnt);
                chk("rc32",  if32.run_count, h_runs);
                chk("dv4",   if4.data_valid, m_dv[2]);
                chk("do4",   if4.data_out, m_do[2]);
                chk("sv4",   if4.sig_valid, m_sv);
                chk("sig4",  if4.sig_out, h_sig);
                chk("cnt4",  if4.word_cnt_out, (h_cnt > 15) ? 15 : h_cnt);
                chk("rc4",   if4.run_count, h_runs % 16);

                // advance with the inputs the DUTs sample at the next rising edge
                wx = '0; fx = '0; nw = 0;
                for (int c = 0; c < NC; c++) begin
                    if (ch_write[c]) begin
                        wx = wx ^ ch_din[c*DW +: DW];
                        fx = fx ^ bytes_xor(ch_din[c*DW +: DW]);
                        nw++;
                    end
                end
                m_dv[2] = m_dv[1]; m_do[2] = m_do[1];
                m_dv[1] = m_dv[0]; m_do[1] = m_do[0];
                m_dv[0] = (nw > 0); m_do[0] = fold4(fx);

                if (mode == 0 && ap_start) begin
                    mode = 1; start_n = cyc; m_sig = '0; m_cnt = 0;
                end
                if ((mode == 1 || (mode == 2 && cyc <= last_collect)) && nw > 0) begin
                    m_sig = {m_sig[30:0], m_sig[31]} ^ wx;
                    m_cnt = m_cnt + nw;
                end
                if (mode == 1 && cyc > start_n && ap_done) begin
                    mode = 2; last_collect = cyc + 1; report_at = cyc + 3;
                end
                if (mode == 2 && cyc == report_at) begin
                    h_sig = m_sig; h_cnt = m_cnt; h_runs = h_runs + 1; mode = 0;
                end
                m_sv = (mode == 2) && (cyc + 1 == report_at);
                cyc++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [1:0] wr, input logic [31:0] d0, input logic [31:0] d1,
                         input logic st, input logic dn);
        ch_write = wr; ch_din = {d1, d0}; ap_start = st; ap_done = dn;
        $display("[TB] t=%0t wr=%b ch0=%h ch1=%h start=%b done=%b", $time, wr, d0, d1, st, dn);
        @(posedge clk); #1;
        ch_write = '0; ch_din = '0; ap_start = 1'b0; ap_done = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    endtask

    task automatic wait_report(output int k);
        k = 0;
        while (if32.sig_valid !== 1'b1 && k < 12) begin
            @(posedge clk); #1;
            k++;
        end
    endtask

    initial begin
        int k;
        // model pins against hand-computed values
        chk("pin_fold_12345678", fold4(bytes_xor(32'h12345678)), 4'h8);
        chk("pin_fold_pair", fold4(bytes_xor(32'h12345678) ^ bytes_xor(32'h000000FF)), 4'h8);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        // single write on ch0
        drive(2'b01, 32'h12345678, 32'h0, 1'b0, 1'b0);
        idle(2);
        chk("s1_dv", if32.data_valid, 1);
        chk("s1_do", if32.data_out, 4'h8);
        idle(1);
        chk("s1_dv_one_cycle", if32.data_valid, 0);

        // simultaneous writes, then ch1 alone
        drive(2'b11, 32'h12345678, 32'h000000FF, 1'b0, 1'b0);
        drive(2'b10, 32'h0, 32'h000000FF, 1'b0, 1'b0);
        idle(1);
        chk("s2_pair_do", if32.data_out, 4'h8);
        idle(1);
        chk("s2_ch1_dv", if32.data_valid, 1);
        chk("s2_ch1_do", if32.data_out, 4'h0);
        idle(2);

        // two identical runs
        for (int r = 1; r <= 2; r++) begin
            drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
            drive(2'b01, 32'h00000001, 32'h0, 1'b0, 1'b0);
            drive(2'b10, 32'h0, 32'h80000000, 1'b0, 1'b1);
            wait_report(k);
            chk("s3_report_delay", k, 2);
            idle(1);
            chk("s3_sig", if32.sig_out, 32'h80000002);
            chk("s3_cnt", if32.word_cnt_out, 2);
            chk("s3_runs", if32.run_count, r);
            idle(2);
        end

        // same-cycle pair
        drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
        drive(2'b11, 32'h00000001, 32'h80000000, 1'b0, 1'b0);
        drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
        wait_report(k);
        idle(1);
        chk("s4_sig", if32.sig_out, 32'h80000001);
        chk("s4_cnt", if32.word_cnt_out, 2);
        chk("s4_runs", if32.run_count, 3);
        idle(2);

        // 20 writes: 4-bit counter saturates
        drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) drive(2'b01, 32'h01010101 * i + 32'd5, 32'h0, 1'b0, 1'b0);
        drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
        wait_report(k);
        idle(1);
        chk("s5_cnt4_sat", if4.word_cnt_out, 4'hF);
        chk("s5_cnt32", if32.word_cnt_out, 20);
        chk("s5_runs4", if4.run_count, 4);

        // writes in IDLE reach data_out but not the counters
        for (int i = 0; i < 3; i++) drive(2'b01, 32'h000000A5, 32'h0, 1'b0, 1'b0);
        chk("s5_idle_dv", if32.data_valid, 1);
        chk("s5_idle_do", if32.data_out, 4'hF);
        idle(6);
        chk("s5_idle_cnt4", if4.word_cnt_out, 4'hF);
        chk("s5_idle_runs", if32.run_count, 4);

        // reset mid-run with writes in flight
        drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
        drive(2'b11, 32'hDEADBEEF, 32'h01234567, 1'b0, 1'b0);
        ch_write = 2'b01; ch_din = {32'h0, 32'h12345678};
        @(posedge clk); #1;
        rst_n = 1'b0;
        ch_write = '0; ch_din = '0;
        #1;
        chk("s6_rst_dv", if32.data_valid, 0);
        chk("s6_rst_runs", if32.run_count, 0);
        chk("s6_rst_sig", if32.sig_out, 0);
        chk("s6_rst_sv", if32.sig_valid, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);
        drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
        drive(2'b01, 32'h00000001, 32'h0, 1'b0, 1'b0);
        drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
        wait_report(k);
        chk("s6_report_delay", k, 2);
        idle(1);
        chk("s6_runs", if32.run_count, 1);
        chk("s6_sig", if32.sig_out, 32'h00000001);
        chk("s6_cnt", if32.word_cnt_out, 1);
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end
endmodule
